// File: rtl/oa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oa_pkg
// Purpose  : Shared types and helpers for the online (MSD-first) adder tree.
//            - clog2      : ceiling log2 used for tree depth and counter widths
//            - sd_digit_t : radix-2 signed digit carried as (p,n), value p-n
//            - SD_ZERO    : the zero digit injected while flushing
//            - state_t    : frame sequencer states
// Revision : 1.0 - initial release
// ============================================================================
package oa_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic p;
    logic n;
  } sd_digit_t;

  localparam sd_digit_t SD_ZERO = '{p: 1'b0, n: 1'b0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/oa_tree_param_if.sv
`default_nettype none
// ============================================================================
// Module   : oa_tree_param_if
// Purpose  : Digit-column input / result-digit output bundle of the online
//            adder tree.
// Ports    : in_valid/in_first/x_p/x_n  -> column stream into the tree
//            in_ready                   <- tree accepts a column this cycle
//            z_p/z_n/out_valid/out_first/out_last <- framed result digits
//            busy/err                   <- frame in progress / sticky error
//            Modport slave is the tree side, master the producer/consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface oa_tree_param_if #(
  parameter int N_IN = 8
);
  logic            in_valid;
  logic            in_first;
  logic            in_ready;
  logic [N_IN-1:0] x_p;
  logic [N_IN-1:0] x_n;
  logic            z_p;
  logic            z_n;
  logic            out_valid;
  logic            out_first;
  logic            out_last;
  logic            busy;
  logic            err;

  modport slave (
    input  in_valid, in_first, x_p, x_n,
    output in_ready, z_p, z_n, out_valid, out_first, out_last, busy, err
  );

  modport master (
    output in_valid, in_first, x_p, x_n,
    input  in_ready, z_p, z_n, out_valid, out_first, out_last, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/oa_stage.sv
`default_nettype none
// ============================================================================
// Module   : oa_stage
// Purpose  : One radix-2 signed-digit online adder, z = (a+b)/2, one digit per
//            enabled step, first digit OA_DELAY steps after the first input.
// Ports    : clk, rst (async, active-low), i_en (step enable),
//            i_a/i_b input digits, o_z registered output digit.
// Revision : 1.0 - initial release
// ============================================================================
module oa_stage
  import oa_pkg::*;
#(
  parameter int OA_DELAY = 2   // must be >= 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire logic      i_en,
  input  wire sd_digit_t i_a,
  input  wire sd_digit_t i_b,
  output sd_digit_t      o_z
);

  // Column sum s_j = a_j + b_j in [-2,2]. s_j/2 contributes s_j at weight
  // 2^-(j+1) of z, so s_j is split into a transfer t_j (weight 2^-j of z) and
  // a residue u_j (weight 2^-(j+1)). The sign of s_{j+1} steers the split so
  // that u_j + t_{j+1} always lands in {-1,0,+1}.
  logic signed [2:0] w_s_cur;
  logic signed [1:0] w_t;
  logic signed [1:0] w_u;
  logic signed [1:0] w_z;
  logic              w_next_nonneg;

  logic signed [2:0] r_s_prev;
  logic signed [1:0] r_u_prev;
  sd_digit_t         r_pipe [OA_DELAY-1];

  assign w_s_cur       = $signed(3'(i_a.p) + 3'(i_b.p) - 3'(i_a.n) - 3'(i_b.n));
  assign w_next_nonneg = ~w_s_cur[2];

  always_comb begin
    w_t = 2'sd0;
    w_u = 2'sd0;
    case (r_s_prev)
      3'sd2:  begin w_t = 2'sd1;  w_u = 2'sd0; end
      -3'sd2: begin w_t = -2'sd1; w_u = 2'sd0; end
      3'sd1: begin
        if (w_next_nonneg) begin w_t = 2'sd1; w_u = -2'sd1; end
        else               begin w_t = 2'sd0; w_u = 2'sd1;  end
      end
      -3'sd1: begin
        if (w_next_nonneg) begin w_t = 2'sd0;  w_u = -2'sd1; end
        else               begin w_t = -2'sd1; w_u = 2'sd1;  end
      end
      default: begin w_t = 2'sd0; w_u = 2'sd0; end
    endcase
  end

  assign w_z = r_u_prev + w_t;

  // The digit produced combinationally in step k is digit k; one register
  // gives an online delay of 2, the remaining OA_DELAY-2 registers pad it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_prev <= 3'sd0;
      r_u_prev <= 2'sd0;
      for (int i = 0; i < OA_DELAY-1; i++) begin
        r_pipe[i] <= SD_ZERO;
      end
    end else if (i_en) begin
      r_s_prev    <= w_s_cur;
      r_u_prev    <= w_u;
      r_pipe[0].p <= (w_z == 2'sd1);
      r_pipe[0].n <= (w_z == -2'sd1);
      for (int i = 1; i < OA_DELAY-1; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_z = r_pipe[OA_DELAY-2];

endmodule

`default_nettype wire

// File: rtl/oa_tree_param.sv
`default_nettype none
// ============================================================================
// Module   : oa_tree_param
// Purpose  : Balanced binary tree of online adders summing N_IN signed-digit
//            operands MSD-first; result Z = sum(x_i)/N_IN, DIGITS+LEVELS
//            digits, with frame sequencing, stall, flush and output framing.
// Ports    : clk, rst (async, active-low), bus (oa_tree_param_if.slave).
// Revision : 1.0 - initial release
// ============================================================================
module oa_tree_param
  import oa_pkg::*;
#(
  parameter int N_IN     = 8,
  parameter int DIGITS   = 16,
  parameter int OA_DELAY = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  oa_tree_param_if.slave  bus
);

  localparam int LEVELS     = clog2(N_IN);
  localparam int c_lat      = LEVELS * OA_DELAY;
  localparam int c_flush    = c_lat + LEVELS;
  localparam int c_last     = DIGITS + c_flush - 1;
  localparam int c_pos_w    = clog2(c_last + 1);

  // r_pos counts steps since the in_first step (that step is position 0).
  // Positions 0..DIGITS-1 consume columns, the rest are flush steps.
  localparam logic [c_pos_w-1:0] c_pos_last_col = c_pos_w'(DIGITS - 1);
  localparam logic [c_pos_w-1:0] c_pos_lat      = c_pos_w'(c_lat);
  localparam logic [c_pos_w-1:0] c_pos_last     = c_pos_w'(c_last);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_pos_w-1:0] r_pos;
  logic               r_err;
  logic               w_step;
  logic               w_flush;
  logic               w_in_ready;
  logic               w_busy;
  logic               w_out_valid;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        // r_pos is 0 here, so a single-digit frame goes straight to FLUSH.
        if (bus.in_valid && bus.in_first)
          w_state_nxt = (r_pos == c_pos_last_col) ? FLUSH : ACCEPT;
      end
      ACCEPT: begin
        if (bus.in_valid && (r_pos == c_pos_last_col)) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (r_pos == c_pos_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_in_ready = 1'b1;
    w_busy     = 1'b0;
    w_step     = 1'b0;
    w_flush    = 1'b0;
    case (r_state)
      IDLE: begin
        w_step = bus.in_valid & bus.in_first;
      end
      ACCEPT: begin
        w_busy = 1'b1;
        w_step = bus.in_valid;
      end
      FLUSH: begin
        w_busy     = 1'b1;
        w_in_ready = 1'b0;
        w_step     = 1'b1;
        w_flush    = 1'b1;
      end
      default: begin
        w_in_ready = 1'b1;
      end
    endcase
  end

  // ---------------- step position counter ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos <= '0;
    end else if (w_step) begin
      if (r_pos == c_pos_last) r_pos <= '0;
      else                     r_pos <= r_pos + 1'b1;
    end
  end

  // ---------------- sticky protocol error ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (bus.in_valid) begin
      if ((r_state == IDLE && !bus.in_first) || (r_state == ACCEPT && bus.in_first))
        r_err <= 1'b1;
    end
  end

  // ---------------- adder tree ----------------
  // Heap numbering: node i (1..N_IN-1) adds nodes 2i and 2i+1; leaves are
  // nodes N_IN..2*N_IN-1. Each level halves, so the root is sum/N_IN.
  sd_digit_t w_node [1:2*N_IN-1];

  for (genvar k = 0; k < N_IN; k++) begin : g_leaf
    assign w_node[N_IN+k] = w_flush ? SD_ZERO : {bus.x_p[k], bus.x_n[k]};
  end

  for (genvar i = 1; i < N_IN; i++) begin : g_node
    oa_stage #(
      .OA_DELAY (OA_DELAY)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_step),
      .i_a  (w_node[2*i]),
      .i_b  (w_node[2*i+1]),
      .o_z  (w_node[i])
    );
  end

  // ---------------- output framing ----------------
  // Root digit 1 is visible at position c_lat; the last digit coincides with
  // the final flush step.
  assign w_out_valid   = w_step && (r_pos >= c_pos_lat);

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.err       = r_err;
  assign bus.out_valid = w_out_valid;
  assign bus.out_first = w_out_valid && (r_pos == c_pos_lat);
  assign bus.out_last  = w_out_valid && (r_pos == c_pos_last);
  assign bus.z_p       = w_out_valid & w_node[1].p;
  assign bus.z_n       = w_out_valid & w_node[1].n;

endmodule

`default_nettype wire

// File: tb/tb_oa_tree_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_oa_tree_param
// Purpose  : Self-checking bench for oa_tree_param (N_IN=8, DIGITS=8,
//            OA_DELAY=2). Frames are queued with their exact expected value
//            and timing; a negedge monitor decodes result digits and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oa_tree_param;

  localparam int TB_N   = 8;
  localparam int TB_DIG = 8;
  localparam int TB_OAD = 2;
  localparam int TB_L   = 3;
  localparam int TB_LAT = TB_L * TB_OAD;        // 6 steps
  localparam int TB_F   = TB_LAT + TB_L;        // 9 flush cycles
  localparam int TB_NO  = TB_DIG + TB_L;        // 11 result digits

  typedef struct {
    longint val;        // Z scaled by 2^(DIGITS+LEVELS)
    int     first_cyc;
    int     last_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  exp_t            exp_q [$];
  logic [TB_N-1:0] fp [TB_DIG];
  logic [TB_N-1:0] fn [TB_DIG];

  oa_tree_param_if #(.N_IN(TB_N)) bus ();

  oa_tree_param #(
    .N_IN     (TB_N),
    .DIGITS   (TB_DIG),
    .OA_DELAY (TB_OAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint req);
    n_checks = n_checks + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: Z*2^(D+L) = sum_i X_i*2^D because 2^L = N_IN; X_i*2^D is the
  // operand's integer digit sum weighted MSD-first.
  function automatic longint model_value();
    longint s;
    s = 0;
    for (int j = 0; j < TB_DIG; j++)
      for (int i = 0; i < TB_N; i++)
        s += (longint'(fp[j][i]) - longint'(fn[j][i])) * (longint'(1) << (TB_DIG-1-j));
    return s;
  endfunction

  task automatic rand_frame();
    for (int j = 0; j < TB_DIG; j++) begin
      fp[j] = TB_N'($urandom);
      fn[j] = TB_N'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Drives one frame; returns on the cycle the last result digit is due, so
  // a following call starts the next frame on the cycle after out_last.
  task automatic send_frame(input int stall_after, input int stall_len,
                            input int refirst_col, input int abort_col);
    int   c0;
    int   colcyc [TB_DIG+1];
    exp_t e;
    @(posedge clk); #1;
    c0 = cyc;
    for (int j = 1; j <= TB_DIG; j++)
      colcyc[j] = c0 + j - 1 + ((stall_len > 0 && j > stall_after) ? stall_len : 0);
    if (abort_col == 0) begin
      e.val       = model_value();
      e.first_cyc = (TB_LAT + 1 <= TB_DIG) ? colcyc[TB_LAT+1]
                                           : colcyc[TB_DIG] + (TB_LAT + 1 - TB_DIG);
      e.last_cyc  = colcyc[TB_DIG] + TB_F;
      exp_q.push_back(e);
    end
    for (int j = 1; j <= TB_DIG; j++) begin
      if (j == abort_col) begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      bus.in_valid = 1'b1;
      bus.in_first = (j == 1) || (j == refirst_col);
      bus.x_p      = fp[j-1];
      bus.x_n      = fn[j-1];
      if (j == 1) begin
        check("busy_at_first", longint'(bus.busy), 0);
        check("ready_at_first", longint'(bus.in_ready), 1);
      end
      if (j == 2 && stall_after != 1) check("busy_after_first", longint'(bus.busy), 1);
      @(posedge clk); #1;
      if (j == stall_after && stall_len > 0) begin
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.x_p      = TB_N'($urandom);
        bus.x_n      = TB_N'($urandom);
        repeat (stall_len) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.x_p      = TB_N'($urandom);
    bus.x_n      = TB_N'($urandom);
    repeat (TB_F - 1) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic   m_active;
  longint m_acc;
  int     m_cnt;
  int     m_low;
  exp_t   m_e;

  always @(negedge clk) begin
    if (!rst) begin
      m_active = 1'b0;
      m_acc    = 0;
      m_cnt    = 0;
      m_low    = 0;
    end else begin
      if (!bus.in_ready) m_low = m_low + 1;
      if (bus.out_valid) begin
        if (bus.out_first) begin
          m_active = 1'b1;
          m_acc    = 0;
          m_cnt    = 0;
          if (exp_q.size() != 0) check("first_cycle", cyc, exp_q[0].first_cyc);
        end
        check("out_in_frame", longint'(m_active && exp_q.size() != 0), 1);
        m_acc = m_acc * 2 + (longint'(bus.z_p) - longint'(bus.z_n));
        m_cnt = m_cnt + 1;
        if (bus.out_last && exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          check("z_value", m_acc, m_e.val);
          check("digit_count", m_cnt, TB_NO);
          check("last_cycle", cyc, m_e.last_cyc);
          check("ready_low_cycles", m_low, TB_F);
          m_active = 1'b0;
          m_low    = 0;
        end
      end else begin
        check("z_zero_idle", longint'({bus.z_p, bus.z_n}), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.x_p      = '0;
    bus.x_n      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(bus.in_ready), 1);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_err", longint'(bus.err), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    rst = 1'b1;

    // digit 1 of every operand = +1 -> Z = +0.5
    for (int j = 0; j < TB_DIG; j++) begin fp[j] = '0; fn[j] = '0; end
    fp[0] = 8'hFF;
    send_frame(0, 0, 0, 0);
    check("err_after_A", longint'(bus.err), 0);

    // operand 0 = 0.11111111, operands 1..7 = -0.11111111
    for (int j = 0; j < TB_DIG; j++) begin fp[j] = 8'h01; fn[j] = 8'hFE; end
    send_frame(0, 0, 0, 0);
    check("err_after_B", longint'(bus.err), 0);

    // same frame, 3-cycle stall after column 4
    send_frame(4, 3, 0, 0);

    // reset at column 5, then an all-zero frame
    send_frame(0, 0, 0, 5);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_ready", longint'(bus.in_ready), 1);
    for (int j = 0; j < TB_DIG; j++) begin fp[j] = '0; fn[j] = '0; end
    send_frame(0, 0, 0, 0);

    // in_first repeated at column 3
    rand_frame();
    send_frame(0, 0, 3, 0);
    check("err_refirst", longint'(bus.err), 1);

    // stray in_valid in IDLE
    do_reset();
    check("err_cleared", longint'(bus.err), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_first = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("err_stray", longint'(bus.err), 1);
    check("busy_stray", longint'(bus.busy), 0);

    // back-to-back random frames, some with random stalls
    for (int f = 0; f < 8; f++) begin
      rand_frame();
      if (f < 2) send_frame(0, 0, 0, 0);
      else       send_frame(int'($urandom_range(1, TB_DIG-1)), int'($urandom_range(0, 3)), 0, 0);
    end

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/oa_tree_param.md
Name: oa_tree_param

Overview:
- Parametrised online (MSD-first, digit-serial) adder tree that sums N_IN radix-2 signed-digit operands.
- Each digit is carried as a (p,n) bit pair with value p−n ∈ {−1,0,+1}.
- Built as a balanced binary tree of LEVELS = log2(N_IN) online-adder stages. It adds frame sequencing, a stall-capable common enable, automatic flush and output framing, none of which the fixed 8-input tree has.
- Sits after the DSLOT multiplier array and feeds the activation/accumulator stage.

Parameters:
- N_IN, 8, number of operands; power of two, 2..64.
- DIGITS, 16, input digits per operand per frame (MSD first, weights 2^-1..2^-DIGITS).
- OA_DELAY, 2, online delay of one adder stage in enabled cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input digit column present this cycle.
- in_first  input  1  qualifies the MSD column of a frame (with in_valid).
- in_ready  output  1  block accepts a column this cycle.
- x_p  input  N_IN  positive bits, operand i at bit i.
- x_n  input  N_IN  negative bits, operand i at bit i.
- z_p, z_n  output  1  result digit pair.
- out_valid  output  1  z digit valid this cycle.
- out_first  output  1  with out_valid: first (weight 2^-1) result digit.
- out_last  output  1  with out_valid: final result digit.
- busy  output  1  frame in progress (ACCEPT or FLUSH).
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all stage registers, counters and outputs clear to 0; in_ready=1.
  - Mid-frame reset discards the frame with no partial output; first frame after release behaves normally.
- States:
  - IDLE: in_ready=1. in_valid&in_first → ACCEPT, and that column is consumed as digit 1. in_valid without in_first is ignored and sets err.
  - ACCEPT: in_ready=1; counts consumed columns. When column DIGITS is consumed → FLUSH.
  - FLUSH: in_ready=0; zero digits (p=n=0) are injected into every leaf each cycle. Lasts F = LEVELS*OA_DELAY + LEVELS cycles, then → IDLE.
- Tree stepping:
  - step = (ACCEPT & in_valid) | (IDLE & in_valid & in_first) | FLUSH.
  - All stages advance only when step=1; otherwise everything holds.
  - A gap in in_valid during ACCEPT stalls the whole tree losslessly.
- Error conditions:
  - in_first during ACCEPT sets err; the column is consumed as an ordinary digit.
  - err clears only on reset.
- Adder stage:
  - Each stage computes w = (a+b)/2 as an online sum, emitting one digit per step after OA_DELAY steps.
  - Output digits are always in {−1,0,+1}; (p,n)=(1,1) is legal and equals 0.
- Result:
  - Z = (Σ x_i)/N_IN as a digit stream of DIGITS+LEVELS digits, weights 2^-1..2^-(DIGITS+LEVELS). Exact: no rounding or truncation.
  - Digit encoding is redundant and not unique; only the value is specified.
- Latency: first output digit appears on the step LEVELS*OA_DELAY steps after the in_first step.
- Output framing:
  - out_valid=step & (output index within 1..DIGITS+LEVELS). out_first at index 1, out_last at index DIGITS+LEVELS.
  - z_p, z_n = 0 whenever out_valid=0.
- Back-to-back frames: in_first is accepted only in IDLE. The next frame may start on the cycle after out_last, when state has returned to IDLE.

Decomposition:
- Shared package oa_pkg holds:
  - clog2 function;
  - sd_digit_t struct {p,n};
  - SD_ZERO constant;
  - state enum {IDLE, ACCEPT, FLUSH}.
- Sub-module oa_stage: one online adder (a,b → z) with enable, async active-low rst and internal online delay OA_DELAY. Instantiated N_IN−1 times via generate.
- Top level owns the FSM, counters and framing.

Test Plan (N_IN=8, DIGITS=8, OA_DELAY=2, LEVELS=3: 6-step latency, 11 output digits, F=9):
- All operands digit 1 = +1 (x_p=0xFF), rest 0, contiguous → out_first 6 cycles after in_first; 11 digits decode to +0.5; out_last on the 11th; then IDLE.
- Operand 0 = 0.11111111, operands 1..7 = −0.11111111 → Z = −6·(255/256)/8 exactly; err=0.
- Same frame with in_valid low for 3 cycles after column 4 → identical digit values; out_valid gaps aligned to the stall; total output count still 11.
- rst pulsed low at column 5, then a fresh all-zero frame → no out_valid until the new frame; Z=0; busy asserts 1 cycle after in_first.
- in_first re-asserted at column 3 → err=1 (sticky); frame completes normally. in_valid without in_first in IDLE → ignored, err=1.
- Two back-to-back frames (second in_first the cycle after out_last) → both results correct; in_ready=0 for exactly 9 cycles per frame.
